// File: rtl/fetch_sequencer_if.sv
// Issue handshake carrying one decoded instruction from the fetch sequencer to the execute stage.
interface fetch_sequencer_if;
  localparam int unsigned DW = 8;

  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] ir_opcode;
  logic [DW-1:0] ir_operand;
  logic          ir_twobyte;

  modport master (output instr_valid, ir_opcode, ir_operand, ir_twobyte, input instr_ready);
  modport slave  (input instr_valid, ir_opcode, ir_operand, ir_twobyte, output instr_ready);
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequencing stage: reads opcode/operand bytes at the PC, steps or
// reloads the external program counter, and issues decoded instructions to execute.
module fetch_sequencer #(
  parameter logic [7:0] OP_JMP  = 8'hC0,
  parameter logic [7:0] OP_JZ   = 8'hC1,
  parameter logic [7:0] OP_HALT = 8'hFF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [7:0]          pc_value,
  output logic                pc_advance,
  output logic                pc_setvalue,
  output logic [7:0]          pc_valuein,
  output logic                pc_decrement,
  output logic [7:0]          mem_addr,
  output logic                mem_rd,
  input  logic [7:0]          mem_rdata,
  input  logic                mem_ready,
  input  logic                z_flag,
  fetch_sequencer_if.master   iss,
  output logic                halted
);

  localparam int unsigned DW = 8;

  typedef enum logic [3:0] {
    FETCH_OP,
    STEP_OP,
    FETCH_ARG,
    STEP_ARG,
    DECODE,
    ISSUE,
    JMP_SET,
    JMP_STEP,
    HALT
  } state_t;

  state_t state;

  // Memory reads always target the live counter value.
  assign mem_addr     = pc_value;
  assign mem_rd       = (state == FETCH_OP) || (state == FETCH_ARG);
  assign pc_decrement = 1'b0;

  // Outputs are loaded together with the state they belong to, so every strobe
  // (notably pc_advance, which clocks the counter) comes straight from a flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= FETCH_OP;
      pc_advance      <= 1'b0;
      pc_setvalue     <= 1'b0;
      pc_valuein      <= DW'(0);
      iss.instr_valid <= 1'b0;
      iss.ir_opcode   <= DW'(0);
      iss.ir_operand  <= DW'(0);
      iss.ir_twobyte  <= 1'b0;
      halted          <= 1'b0;
    end else begin
      pc_advance      <= 1'b0;
      pc_setvalue     <= 1'b0;
      iss.instr_valid <= 1'b0;
      case (state)
        FETCH_OP: begin
          if (mem_ready) begin
            iss.ir_opcode  <= mem_rdata;
            iss.ir_twobyte <= mem_rdata[7];
            pc_advance     <= 1'b1;
            state          <= STEP_OP;
          end
        end
        STEP_OP: begin
          if (iss.ir_opcode[7]) begin
            state <= FETCH_ARG;
          end else begin
            iss.ir_operand <= DW'(0);
            state          <= DECODE;
          end
        end
        FETCH_ARG: begin
          if (mem_ready) begin
            iss.ir_operand <= mem_rdata;
            pc_advance     <= 1'b1;
            state          <= STEP_ARG;
          end
        end
        STEP_ARG: state <= DECODE;
        DECODE: begin
          if (iss.ir_opcode == OP_HALT) begin
            halted <= 1'b1;
            state  <= HALT;
          end else if ((iss.ir_opcode == OP_JMP) || ((iss.ir_opcode == OP_JZ) && z_flag)) begin
            pc_setvalue <= 1'b1;
            pc_valuein  <= iss.ir_operand;
            state       <= JMP_SET;
          end else if (iss.ir_opcode == OP_JZ) begin
            state <= FETCH_OP;
          end else begin
            iss.instr_valid <= 1'b1;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          if (iss.instr_ready) begin
            state <= FETCH_OP;
          end else begin
            iss.instr_valid <= 1'b1;
          end
        end
        // Load select was raised a cycle earlier and holds across the counter edge.
        JMP_SET: begin
          pc_setvalue <= 1'b1;
          pc_advance  <= 1'b1;
          state       <= JMP_STEP;
        end
        JMP_STEP: state <= FETCH_OP;
        HALT:     state <= HALT;
        default:  state <= FETCH_OP;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed latency/handshake cases plus random programs
// checked against an instruction-level interpreter of the program memory.
module tb_fetch_sequencer;
  localparam int K_LOOP  = 0;
  localparam int K_ISSUE = 1;
  localparam int K_HALT  = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pc_value, pc_valuein, mem_addr, mem_rdata;
  logic       pc_advance, pc_setvalue, pc_decrement, mem_rd, halted;
  logic       mem_ready = 1'b1;
  logic       z_flag = 1'b0;

  logic [7:0] mem [256];
  logic [7:0] pc = 8'h00;
  logic       force_pc = 1'b0;
  logic [7:0] force_val = 8'h00;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  logic [7:0] mpc = 8'h00;
  logic       mz = 1'b0;

  fetch_sequencer_if iss();

  fetch_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .pc_value     (pc_value),
    .pc_advance   (pc_advance),
    .pc_setvalue  (pc_setvalue),
    .pc_valuein   (pc_valuein),
    .pc_decrement (pc_decrement),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .z_flag       (z_flag),
    .iss          (iss),
    .halted       (halted)
  );

  always #5 clock = ~clock;

  assign pc_value  = pc;
  assign mem_rdata = mem[mem_addr];

  // External program counter: steps or loads on the rising edge of pc_advance.
  always @(posedge pc_advance or posedge force_pc) begin
    if (force_pc)         pc <= force_val;
    else if (pc_setvalue) pc <= pc_valuein;
    else                  pc <= pc + 8'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    cyc++;
  endtask

  // Reset, preload the counter, release on a falling edge; returns in cycle 0 (FETCH_OP).
  task automatic start(input logic [7:0] pc0);
    reset     = 1'b1;
    force_val = pc0;
    force_pc  = 1'b1;
    #1;
    force_pc  = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic wait_valid(input int limit);
    while (!iss.instr_valid && cyc < limit) tick();
  endtask

  task automatic fill(input logic [7:0] v);
    for (int a = 0; a < 256; a++) mem[a] = v;
  endtask

  // Architectural walk from mpc: skip jumps and untaken JZ, stop at the next issued
  // instruction or at HALT. A long run with neither is an endless jump loop.
  function automatic void next_event(output int kind, output logic [7:0] op,
                                     output logic [7:0] arg, output logic two);
    logic [7:0] o, a, p1;
    kind = K_LOOP; op = 8'h00; arg = 8'h00; two = 1'b0;
    for (int i = 0; i < 600; i++) begin
      o  = mem[mpc];
      p1 = mpc + 8'd1;
      a  = o[7] ? mem[p1] : 8'h00;
      if (o == 8'hFF) begin
        kind = K_HALT; op = o; return;
      end
      if (o == 8'hC0 || (o == 8'hC1 && mz)) begin
        mpc = a;
        continue;
      end
      mpc = mpc + (o[7] ? 8'd2 : 8'd1);
      if (o == 8'hC1) continue;
      kind = K_ISSUE; op = o; arg = a; two = o[7];
      return;
    end
  endfunction

  initial begin
    int adv, vcyc, svc, svfirst, adv_sv, vseen, ek;
    logic [7:0] eo, ea;
    logic et, have_exp, prev_valid, prev_ready, prev_sv;

    iss.instr_ready = 1'b1;
    fill(8'h01);

    // Reset values
    #3;
    chk("rst_pc_advance", 32'(pc_advance), 32'h0);
    chk("rst_pc_setvalue", 32'(pc_setvalue), 32'h0);
    chk("rst_pc_valuein", 32'(pc_valuein), 32'h0);
    chk("rst_pc_decrement", 32'(pc_decrement), 32'h0);
    chk("rst_instr_valid", 32'(iss.instr_valid), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_ir_opcode", 32'(iss.ir_opcode), 32'h0);
    chk("rst_ir_operand", 32'(iss.ir_operand), 32'h0);
    chk("rst_ir_twobyte", 32'(iss.ir_twobyte), 32'h0);
    chk("rst_mem_rd", 32'(mem_rd), 32'h1);

    // One-byte instruction latency
    mem[0] = 8'h12;
    start(8'h00);
    chk("t1_addr0", 32'(mem_addr), 32'h00);
    chk("t1_rd0", 32'(mem_rd), 32'h1);
    adv = 0; vcyc = -1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      adv += int'(pc_advance);
      if (iss.instr_valid && vcyc < 0) vcyc = cyc;
    end
    chk("t1_adv_pulses", 32'(adv), 32'd1);
    chk("t1_valid_cycle", 32'(vcyc), 32'd3);
    chk("t1_opcode", 32'(iss.ir_opcode), 32'h12);
    chk("t1_twobyte", 32'(iss.ir_twobyte), 32'h0);
    chk("t1_operand", 32'(iss.ir_operand), 32'h00);
    tick();
    chk("t1_next_addr", 32'(mem_addr), 32'h01);
    chk("t1_next_rd", 32'(mem_rd), 32'h1);

    // Two-byte instruction with back-pressure
    fill(8'h01);
    mem[0] = 8'h85; mem[1] = 8'h3A;
    iss.instr_ready = 1'b0;
    start(8'h00);
    wait_valid(20);
    chk("t2_valid_cycle", 32'(cyc), 32'd5);
    for (int k = 0; k < 4; k++) begin
      chk("t2_hold_valid", 32'(iss.instr_valid), 32'h1);
      chk("t2_hold_opcode", 32'(iss.ir_opcode), 32'h85);
      chk("t2_hold_operand", 32'(iss.ir_operand), 32'h3A);
      chk("t2_hold_twobyte", 32'(iss.ir_twobyte), 32'h1);
      tick();
    end
    chk("t2_still_valid", 32'(iss.instr_valid), 32'h1);
    iss.instr_ready = 1'b1;
    tick();
    chk("t2_accepted", 32'(iss.instr_valid), 32'h0);
    chk("t2_pc_after", 32'(mem_addr), 32'h02);

    // Unconditional jump
    fill(8'h01);
    mem[0] = 8'hC0; mem[1] = 8'h40;
    start(8'h00);
    svc = 0; svfirst = -1; adv_sv = 0; vseen = 0;
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) tick();
      if (pc_setvalue) begin
        svc++;
        if (svfirst < 0) svfirst = cyc;
        adv_sv += int'(pc_advance);
        chk("t3_valuein", 32'(pc_valuein), 32'h40);
      end
      if (iss.instr_valid) vseen++;
    end
    chk("t3_setvalue_cycles", 32'(svc), 32'd2);
    chk("t3_setvalue_first", 32'(svfirst), 32'd5);
    chk("t3_adv_in_setvalue", 32'(adv_sv), 32'd1);
    chk("t3_no_issue", 32'(vseen), 32'd0);
    chk("t3_target_addr", 32'(mem_addr), 32'h40);
    chk("t3_target_rd", 32'(mem_rd), 32'h1);

    // JZ untaken then taken
    fill(8'h01);
    mem[8'h10] = 8'hC1; mem[8'h11] = 8'h80;
    z_flag = 1'b0;
    start(8'h10);
    for (int k = 0; k < 4; k++) tick();
    chk("t4_nt_rd_c4", 32'(mem_rd), 32'h0);
    tick();
    chk("t4_nt_addr", 32'(mem_addr), 32'h12);
    chk("t4_nt_rd", 32'(mem_rd), 32'h1);
    z_flag = 1'b1;
    start(8'h10);
    for (int k = 0; k < 6; k++) tick();
    chk("t4_tk_rd_c6", 32'(mem_rd), 32'h0);
    tick();
    chk("t4_tk_addr", 32'(mem_addr), 32'h80);
    chk("t4_tk_rd", 32'(mem_rd), 32'h1);
    z_flag = 1'b0;

    // Memory wait states and operand wrap from FF to 00
    fill(8'h01);
    mem[8'hFF] = 8'h8A; mem[8'h00] = 8'h5C;
    mem_ready = 1'b0;
    start(8'hFF);
    for (int k = 0; k < 3; k++) begin
      chk("t5_wait_rd", 32'(mem_rd), 32'h1);
      chk("t5_wait_noadv", 32'(pc_advance), 32'h0);
      tick();
    end
    chk("t5_wait_rd3", 32'(mem_rd), 32'h1);
    mem_ready = 1'b1;
    wait_valid(30);
    chk("t5_valid_cycle", 32'(cyc), 32'd8);
    chk("t5_opcode", 32'(iss.ir_opcode), 32'h8A);
    chk("t5_operand", 32'(iss.ir_operand), 32'h5C);

    // HALT, then reset mid-HALT and mid-ISSUE
    fill(8'h01);
    mem[8'h20] = 8'hFF;
    start(8'h20);
    while (!halted && cyc < 15) tick();
    chk("t6_halted", 32'(halted), 32'h1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t6_halt_rd", 32'(mem_rd), 32'h0);
      chk("t6_halt_adv", 32'(pc_advance), 32'h0);
      chk("t6_halt_valid", 32'(iss.instr_valid), 32'h0);
    end
    reset = 1'b1;
    #1;
    chk("t6_rst_halted", 32'(halted), 32'h0);
    fill(8'h01);
    mem[8'h30] = 8'h12;
    iss.instr_ready = 1'b0;
    start(8'h30);
    wait_valid(20);
    chk("t6_issue_valid", 32'(iss.instr_valid), 32'h1);
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(iss.instr_valid), 32'h0);
    chk("t6_rst_halted2", 32'(halted), 32'h0);
    chk("t6_rst_opcode", 32'(iss.ir_opcode), 32'h00);
    @(negedge clock);
    reset = 1'b0;
    cyc = 0;
    chk("t6_restart_addr", 32'(mem_addr), 32'h31);
    chk("t6_restart_rd", 32'(mem_rd), 32'h1);
    iss.instr_ready = 1'b1;
    wait_valid(20);
    chk("t6_restart_opcode", 32'(iss.ir_opcode), 32'h01);

    // Random programs against the interpreter
    for (int run = 0; run < 4; run++) begin
      for (int a = 0; a < 256; a++) begin
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 2)       mem[a] = 8'hFF;
        else if (r < 10) mem[a] = 8'hC0;
        else if (r < 20) mem[a] = 8'hC1;
        else             mem[a] = 8'($urandom);
      end
      mz = 1'($urandom);
      z_flag = mz;
      mem_ready = 1'b1;
      iss.instr_ready = 1'b1;
      start(8'($urandom));
      mpc = pc;
      have_exp = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0; prev_sv = 1'b0;
      ek = K_LOOP; eo = 8'h00; ea = 8'h00; et = 1'b0;
      for (int c = 0; c < 1500; c++) begin
        if (c > 0) tick();
        mem_ready       = ($urandom_range(0, 3) != 0);
        iss.instr_ready = ($urandom_range(0, 2) != 0);
        if (mem_rd) chk("rnd_addr", 32'(mem_addr), 32'(pc));
        if (prev_valid && !prev_ready) chk("rnd_hold", 32'(iss.instr_valid), 32'h1);
        if (pc_setvalue && !prev_sv) chk("rnd_sv_lead", 32'(pc_advance), 32'h0);
        if ((iss.instr_valid || halted) && !have_exp) begin
          next_event(ek, eo, ea, et);
          have_exp = 1'b1;
        end
        if (iss.instr_valid) begin
          chk("rnd_kind_issue", 32'(ek), 32'(K_ISSUE));
          chk("rnd_opcode", 32'(iss.ir_opcode), 32'(eo));
          chk("rnd_operand", 32'(iss.ir_operand), 32'(ea));
          chk("rnd_twobyte", 32'(iss.ir_twobyte), 32'(et));
        end
        if (halted) begin
          chk("rnd_kind_halt", 32'(ek), 32'(K_HALT));
          chk("rnd_halt_rd", 32'(mem_rd), 32'h0);
          chk("rnd_halt_adv", 32'(pc_advance), 32'h0);
        end
        if (iss.instr_valid && iss.instr_ready) begin
          have_exp = 1'b0;
          mz = 1'($urandom);
          z_flag = mz;
        end
        prev_valid = iss.instr_valid;
        prev_ready = iss.instr_ready;
        prev_sv    = pc_setvalue;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch and sequencing stage for the 8-bit CPU. It reads opcode and operand bytes from program memory at the address held by the program counter. It steps the program counter, and redirects it on jumps by driving the counter's load controls. It hands each decoded instruction to the execute stage over a valid/ready handshake.

## Interface
Parameters:
- OP_JMP, 8'hC0, unconditional jump opcode; two bytes, operand is the target.
- OP_JZ, 8'hC1, jump-if-zero opcode; two bytes, operand is the target.
- OP_HALT, 8'hFF, halt opcode; one byte.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high.
- pc_value  in  8  current program counter value.
- pc_advance  out  1  counter step strobe, connected to the counter's clock input. Driven directly from a flop, so it is glitch-free.
- pc_setvalue  out  1  counter load select.
- pc_valuein  out  8  counter load value.
- pc_decrement  out  1  constant 0.
- mem_addr  out  8  program memory address; combinationally equal to pc_value.
- mem_rd  out  1  read request.
- mem_rdata  in  8  read data; valid when mem_ready=1.
- mem_ready  in  1  read completes in any cycle where mem_rd=1 and mem_ready=1.
- z_flag  in  1  zero flag from the execute stage; sampled in DECODE.
- instr_valid  out  1  instruction available to the execute stage.
- instr_ready  in  1  execute stage accepts the instruction.
- ir_opcode  out  8  opcode byte.
- ir_operand  out  8  operand byte; 8'h00 for one-byte instructions.
- ir_twobyte  out  1  ir_operand is meaningful.
- halted  out  1  sequencer is stopped in HALT.

## Operation
Instruction format:
- opcode[7]=1 → two-byte instruction (opcode, operand).
- opcode[7]=0 → one-byte instruction.

FSM states:
- FETCH_OP: mem_rd=1. On mem_ready, capture mem_rdata into ir_opcode and go to STEP_OP. Without mem_ready, stay.
- STEP_OP: pc_advance=1. Go to FETCH_ARG if ir_opcode[7]=1, else clear ir_operand and go to DECODE.
- FETCH_ARG: mem_rd=1. On mem_ready, capture mem_rdata into ir_operand and go to STEP_ARG.
- STEP_ARG: pc_advance=1. Go to DECODE.
- DECODE, in priority order:
  - OP_HALT → HALT.
  - OP_JMP → JMP_SET.
  - OP_JZ with z_flag=1 → JMP_SET.
  - OP_JZ with z_flag=0 → FETCH_OP; nothing is issued.
  - Anything else → ISSUE.
- ISSUE: instr_valid=1. On instr_ready, go to FETCH_OP.
- JMP_SET: pc_setvalue=1, pc_valuein=ir_operand. Go to JMP_STEP.
- JMP_STEP: pc_setvalue=1, pc_valuein=ir_operand, pc_advance=1. Go to FETCH_OP.
- HALT: halted=1, terminal until reset. mem_rd=0 and pc_advance=0.

Handshake and PC rules:
- ir_opcode, ir_operand and ir_twobyte are held stable while instr_valid=1.
- instr_valid never drops without instr_ready.
- Jumps and OP_HALT are consumed internally and never issued.
- pc_setvalue asserts one cycle before pc_advance rises and stays asserted through that cycle, so the load select is stable at the counter edge.
- PC wrap is the counter's job. A two-byte instruction whose opcode sits at 8'hFF reads its operand from 8'h00.

## Timing
Reset values:
- State = FETCH_OP.
- pc_advance=0, pc_setvalue=0, pc_valuein=8'h00, pc_decrement=0.
- instr_valid=0, halted=0.
- ir_opcode=8'h00, ir_operand=8'h00, ir_twobyte=0.
- mem_rd=1 is combinationally implied by FETCH_OP.

Reset mid-operation:
- Aborts any pending fetch, issue or jump.
- Outputs take their reset values immediately.
- A held instruction is discarded.

Cycle counts:
- pc_value reflects a step by the cycle after STEP_*/JMP_STEP, so the next FETCH uses the updated address.
- Latency with mem_ready tied high:
  - One-byte instruction: instr_valid in cycle 3 after entering FETCH_OP.
  - Two-byte instruction: instr_valid in cycle 5.
  - Taken jump: 7 cycles from the opcode fetch to the fetch at the target.
  - Untaken OP_JZ: 5 cycles.
- Each mem_ready=0 cycle adds one cycle of latency.
- Each instr_ready=0 cycle adds one cycle of latency.
- mem_ready and instr_ready outside FETCH_*/ISSUE are ignored.

## Test plan
- Memory [00]=8'h12, mem_ready=1, instr_ready=1 → mem_addr=00, one pc_advance pulse, instr_valid in cycle 3 with ir_opcode=12, ir_twobyte=0, ir_operand=00; next fetch at 01.
- [00]=8'h85, [01]=8'h3A, instr_ready held 0 for 4 cycles → instr_valid stays 1 with opcode 85 and operand 3A stable throughout; accepted on the first ready; PC=02.
- [00]=C0, [01]=40 → pc_setvalue high for 2 cycles with pc_valuein=40, exactly one pc_advance during the second; next mem_addr=40; instr_valid never asserted.
- OP_JZ at 10 with target 80: z_flag=0 → next fetch at 12; z_flag=1 → next fetch at 80.
- mem_ready low for 3 cycles in FETCH_OP → mem_rd held, no pc_advance until the read completes; opcode at FF with operand fetched from 00.
- OP_HALT → halted=1, no further mem_rd or pc_advance. Reset asserted mid-ISSUE → instr_valid=0 and halted=0 immediately; fetching restarts from the current pc_value.
